redirect_ctrl: RTL

Sequencing controller for the next-PC unit. Each cycle it picks the NPC operation code, PC write enable and pipeline flush, and drives the CTR/LR/SRR0/SRR1/MSR write strobes for branches, `rfi` and external interrupts. It runs a small state machine that holds fetch, drains the pipeline, saves state and only then redirects to the interrupt entry. It sits between the ID-stage decoder/hazard unit and NPC.

---
 rtl/redirect_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/redirect_ctrl.sv
// Next-PC sequencing controller: branch/rfi redirects and the interrupt
// hold -> drain -> save -> jump sequence, with SPR write strobes.
module redirect_ctrl #(
    parameter  int unsigned DRAIN_CYCLES = 2,
    localparam int unsigned NPCOP_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   br_valid,
    input  logic [1:0]             br_type,
    input  logic                   br_lk,
    input  logic                   br_bo2,
    input  logic                   rfi_valid,
    input  logic                   stall,
    input  logic                   irq,
    input  logic                   msr_ee,
    output logic [NPCOP_WIDTH-1:0] npc_op,
    output logic                   pc_we,
    output logic                   flush,
    output logic                   ctr_we,
    output logic                   lr_we,
    output logic                   srr0_we,
    output logic                   srr1_we,
    output logic                   msr_ee_clr,
    output logic                   msr_restore,
    output logic                   int_ack
);

    localparam int unsigned CNT_WIDTH = 4;

    localparam logic [NPCOP_WIDTH-1:0] NPCOP_PLUS4 = NPCOP_WIDTH'(0);
    localparam logic [NPCOP_WIDTH-1:0] NPCOP_B     = NPCOP_WIDTH'(1);
    localparam logic [NPCOP_WIDTH-1:0] NPCOP_BC    = NPCOP_WIDTH'(2);
    localparam logic [NPCOP_WIDTH-1:0] NPCOP_BCCTR = NPCOP_WIDTH'(3);
    localparam logic [NPCOP_WIDTH-1:0] NPCOP_BCLR  = NPCOP_WIDTH'(4);
    localparam logic [NPCOP_WIDTH-1:0] NPCOP_RFI   = NPCOP_WIDTH'(5);
    localparam logic [NPCOP_WIDTH-1:0] NPCOP_INT   = NPCOP_WIDTH'(6);

    // Last drain count before SAVE; unreachable when DRAIN_CYCLES is 0.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SAVE  = 2'd2,
        JUMP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 irq_pend_q, irq_pend_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        irq_pend_d  = irq_pend_q;
        npc_op      = NPCOP_PLUS4;
        pc_we       = 1'b1;
        flush       = 1'b0;
        ctr_we      = 1'b0;
        lr_we       = 1'b0;
        srr0_we     = 1'b0;
        srr1_we     = 1'b0;
        msr_ee_clr  = 1'b0;
        msr_restore = 1'b0;
        int_ack     = 1'b0;

        case (state_q)
            RUN: begin
                if (stall) begin
                    pc_we = 1'b0;
                end else if (irq_pend_q && !br_valid) begin
                    // Hold fetch this cycle; the interrupt is now committed.
                    pc_we   = 1'b0;
                    cnt_d   = '0;
                    state_d = (DRAIN_CYCLES == 0) ? SAVE : DRAIN;
                end else if (rfi_valid) begin
                    npc_op      = NPCOP_RFI;
                    flush       = 1'b1;
                    msr_restore = 1'b1;
                end else begin
                    if (br_valid) begin
                        flush = 1'b1;
                        lr_we = br_lk;
                        case (br_type)
                            2'd0:    npc_op = NPCOP_B;
                            2'd1:    npc_op = NPCOP_BC;
                            2'd2:    npc_op = NPCOP_BCCTR;
                            default: npc_op = NPCOP_BCLR;
                        endcase
                        ctr_we = br_type[0] & ~br_bo2;
                    end
                    irq_pend_d = msr_ee & (irq_pend_q | irq);
                end
            end
            DRAIN: begin
                pc_we = 1'b0;
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = SAVE;
                end
            end
            SAVE: begin
                pc_we      = 1'b0;
                srr0_we    = 1'b1;
                srr1_we    = 1'b1;
                msr_ee_clr = 1'b1;
                state_d    = JUMP;
            end
            default: begin
                npc_op     = NPCOP_INT;
                flush      = 1'b1;
                int_ack    = 1'b1;
                irq_pend_d = 1'b0;
                state_d    = RUN;
            end
        endcase

        // Reset suppresses every strobe and freezes the PC.
        if (!rst_n) begin
            npc_op      = NPCOP_PLUS4;
            pc_we       = 1'b0;
            flush       = 1'b0;
            ctr_we      = 1'b0;
            lr_we       = 1'b0;
            srr0_we     = 1'b0;
            srr1_we     = 1'b0;
            msr_ee_clr  = 1'b0;
            msr_restore = 1'b0;
            int_ack     = 1'b0;
        end
    end

endmodule
